// File: rtl/proj_security_ctrl_if.sv
// Sensor/actuator bundle for the security controller: sensor reports in,
// sector flags and emergency/door commands out.
interface proj_security_ctrl_if;
   logic        fire;
   logic        earth_quake;
   logic [2:0]  mds0;
   logic [2:0]  mds1;
   logic [2:0]  mds2;
   logic [2:0]  mds3;
   logic [2:0]  cam0;
   logic [2:0]  cam1;
   logic [2:0]  cam2;
   logic [2:0]  cam3;
   logic [11:0] access_code;
   logic        sec0;
   logic        sec1;
   logic        sec2;
   logic        sec3;
   logic        door;
   logic        fire_exit;
   logic        fire_dept_alert;
   logic        fire_alarm;
   logic        server_backup_signal;

   // Sensor front-end side: drives reports, consumes commands.
   modport master (
      output fire, earth_quake,
      output mds0, mds1, mds2, mds3,
      output cam0, cam1, cam2, cam3,
      output access_code,
      input  sec0, sec1, sec2, sec3,
      input  door, fire_exit, fire_dept_alert, fire_alarm, server_backup_signal
   );

   // Controller side.
   modport slave (
      input  fire, earth_quake,
      input  mds0, mds1, mds2, mds3,
      input  cam0, cam1, cam2, cam3,
      input  access_code,
      output sec0, sec1, sec2, sec3,
      output door, fire_exit, fire_dept_alert, fire_alarm, server_backup_signal
   );
endinterface

// File: rtl/proj_security_ctrl.sv
// Building security controller: sector intrusion fusion, keypad door unlock
// with hold, and fire/earthquake emergency outputs with hold timers.
module proj_security_ctrl #(
   parameter logic [11:0] ACCESS_CODE = 12'd123,
   parameter int unsigned DOOR_HOLD   = 8,
   parameter int unsigned ALARM_HOLD  = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   proj_security_ctrl_if.slave io
);
   localparam int unsigned DW = $clog2(DOOR_HOLD + 1);
   localparam int unsigned AW = $clog2(ALARM_HOLD + 1);

   localparam logic [DW-1:0] DOOR_RELOAD  = DW'(DOOR_HOLD);
   localparam logic [AW-1:0] ALARM_RELOAD = AW'(ALARM_HOLD);
   // Entering HOLD already consumes the first hold cycle.
   localparam logic [AW-1:0] HOLD_ENTRY   = AW'(ALARM_HOLD - 1);

   typedef enum logic [1:0] {
      EM_IDLE,
      EM_ACTIVE,
      EM_HOLD
   } em_state_t;

   em_state_t     em_state_q, em_state_d;
   logic [AW-1:0] em_cnt_q, em_cnt_d;
   logic [AW-1:0] fire_cnt_q, fire_cnt_d;
   logic [DW-1:0] door_cnt_q, door_cnt_d;

   logic [3:0] sec_q, sec_d;
   logic       door_q, door_d;
   logic       em_on_q, em_on_d;
   logic       fire_alert_q, fire_alert_d;

   logic [2:0] rpt [8];
   logic       emergency;
   logic       code_match;
   logic       code_door;

   assign rpt[0] = io.cam0;
   assign rpt[1] = io.cam1;
   assign rpt[2] = io.cam2;
   assign rpt[3] = io.cam3;
   assign rpt[4] = io.mds0;
   assign rpt[5] = io.mds1;
   assign rpt[6] = io.mds2;
   assign rpt[7] = io.mds3;

   assign emergency  = io.fire || io.earth_quake;
   assign code_match = (io.access_code == ACCESS_CODE);

   // The report's id field picks the sector, not the source it came from.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned and infers a latch.
      sec_d = '0;
      for (int i = 0; i < 8; i++) begin
         if (rpt[i][2]) sec_d[rpt[i][1:0]] = 1'b1;
      end
   end

   always_comb begin
      door_cnt_d = door_cnt_q;
      if (code_match) begin
         door_cnt_d = DOOR_RELOAD;
      end else if (door_cnt_q != '0) begin
         door_cnt_d = door_cnt_q - DW'(1);
      end
      code_door = code_match || (door_cnt_q != '0);
   end

   always_comb begin
      em_state_d = em_state_q;
      em_cnt_d   = em_cnt_q;
      em_on_d    = 1'b0;
      unique case (em_state_q)
         EM_IDLE: begin
            if (emergency) begin
               em_state_d = EM_ACTIVE;
               em_on_d    = 1'b1;
            end
         end
         EM_ACTIVE: begin
            em_on_d = 1'b1;
            if (!emergency) begin
               em_state_d = EM_HOLD;
               em_cnt_d   = HOLD_ENTRY;
            end
         end
         EM_HOLD: begin
            em_on_d = 1'b1;
            if (emergency) begin
               em_state_d = EM_ACTIVE;
            end else if (em_cnt_q == '0) begin
               em_state_d = EM_IDLE;
               em_on_d    = 1'b0;
            end else begin
               em_cnt_d = em_cnt_q - AW'(1);
            end
         end
         default: begin
            em_state_d = EM_IDLE;
         end
      endcase
   end

   // Fire-department alert tracks fire alone, so it keeps a separate timer.
   always_comb begin
      fire_cnt_d = fire_cnt_q;
      if (io.fire) begin
         fire_cnt_d = ALARM_RELOAD;
      end else if (fire_cnt_q != '0) begin
         fire_cnt_d = fire_cnt_q - AW'(1);
      end
      fire_alert_d = io.fire || (fire_cnt_q != '0);
   end

   assign door_d = code_door || em_on_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         em_state_q   <= EM_IDLE;
         em_cnt_q     <= '0;
         fire_cnt_q   <= '0;
         door_cnt_q   <= '0;
         sec_q        <= '0;
         door_q       <= 1'b0;
         em_on_q      <= 1'b0;
         fire_alert_q <= 1'b0;
      end else begin
         em_state_q   <= em_state_d;
         em_cnt_q     <= em_cnt_d;
         fire_cnt_q   <= fire_cnt_d;
         door_cnt_q   <= door_cnt_d;
         sec_q        <= sec_d;
         door_q       <= door_d;
         em_on_q      <= em_on_d;
         fire_alert_q <= fire_alert_d;
      end
   end

   assign io.sec0                 = sec_q[0];
   assign io.sec1                 = sec_q[1];
   assign io.sec2                 = sec_q[2];
   assign io.sec3                 = sec_q[3];
   assign io.door                 = door_q;
   assign io.fire_exit            = em_on_q;
   assign io.fire_alarm           = em_on_q;
   assign io.server_backup_signal = em_on_q;
   assign io.fire_dept_alert      = fire_alert_q;
endmodule

// File: tb/tb_proj_security_ctrl.sv
// Self-checking bench: time-since-event reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_proj_security_ctrl;
   localparam int          DOOR_HOLD   = 8;
   localparam int          ALARM_HOLD  = 16;
   localparam logic [11:0] ACCESS_CODE = 12'd123;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   bit   check_en = 1'b0;
   int   tests = 0;
   int   fails = 0;

   proj_security_ctrl_if bus ();

   proj_security_ctrl #(
      .ACCESS_CODE(ACCESS_CODE),
      .DOOR_HOLD  (DOOR_HOLD),
      .ALARM_HOLD (ALARM_HOLD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .io   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remembers the clock edge index of the last code match,
   // last emergency and last fire; outputs follow from elapsed edges.
   longint   edge_n, last_match, last_em, last_fire;
   logic [3:0] m_sec;

   function automatic logic [3:0] decode_hits();
      logic [23:0] all;
      logic [2:0]  r;
      logic [3:0]  s;
      all = {bus.cam0, bus.cam1, bus.cam2, bus.cam3, bus.mds0, bus.mds1, bus.mds2, bus.mds3};
      s = '0;
      for (int i = 0; i < 8; i++) begin
         r = all[i*3 +: 3];
         if (r[2]) s[r[1:0]] = 1'b1;
      end
      return s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_n     <= 0;
         last_match <= -1000;
         last_em    <= -1000;
         last_fire  <= -1000;
         m_sec      <= '0;
      end else begin
         edge_n <= edge_n + 1;
         if (bus.access_code == ACCESS_CODE) last_match <= edge_n + 1;
         if (bus.fire || bus.earth_quake)    last_em    <= edge_n + 1;
         if (bus.fire)                       last_fire  <= edge_n + 1;
         m_sec <= decode_hits();
      end
   end

   function automatic logic [8:0] model_out();
      logic em, fa, dr;
      em = (edge_n - last_em) <= ALARM_HOLD;
      fa = (edge_n - last_fire) <= ALARM_HOLD;
      dr = ((edge_n - last_match) <= DOOR_HOLD) || em;
      return {m_sec, dr, em, fa, em, em};
   endfunction

   function automatic logic [8:0] dut_out();
      return {bus.sec3, bus.sec2, bus.sec1, bus.sec0, bus.door, bus.fire_exit,
              bus.fire_dept_alert, bus.fire_alarm, bus.server_backup_signal};
   endfunction

   function automatic logic [3:0] dut_sec();
      return {bus.sec3, bus.sec2, bus.sec1, bus.sec0};
   endfunction

   // {door, fire_exit, fire_dept_alert, fire_alarm, server_backup_signal}
   function automatic logic [4:0] dut_emg();
      return {bus.door, bus.fire_exit, bus.fire_dept_alert, bus.fire_alarm, bus.server_backup_signal};
   endfunction

   always @(negedge clk) begin
      if (check_en && rst_n) check("cycle_outputs", 16'(dut_out()), 16'(model_out()));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.fire = 1'b0;  bus.earth_quake = 1'b0;
      bus.cam0 = '0;    bus.cam1 = '0;  bus.cam2 = '0;  bus.cam3 = '0;
      bus.mds0 = '0;    bus.mds1 = '0;  bus.mds2 = '0;  bus.mds3 = '0;
      bus.access_code = '0;
   endtask

   task automatic set_cam(input int i, input logic [2:0] v);
      case (i)
         0: bus.cam0 = v;
         1: bus.cam1 = v;
         2: bus.cam2 = v;
         default: bus.cam3 = v;
      endcase
   endtask

   initial begin
      int door_cnt, alarm_cnt, alert_cnt;
      logic [2:0] v;
      idle_inputs();
      #2 rst_n = 1'b0;
      #1 check("reset_async", 16'(dut_out()), 16'h0);
      cyc(2);
      check("reset_held", 16'(dut_out()), 16'h0);
      rst_n    = 1'b1;
      check_en = 1'b1;

      // Idle reports (detect bit clear) with the valid code.
      bus.cam0 = 3'b000; bus.cam1 = 3'b001; bus.cam2 = 3'b010; bus.cam3 = 3'b011;
      bus.mds0 = 3'b000; bus.mds1 = 3'b001; bus.mds2 = 3'b010; bus.mds3 = 3'b011;
      bus.access_code = 12'd123;
      cyc(1);
      check("idle_sec", 16'(dut_sec()), 16'h0);
      check("idle_emerg", 16'(dut_emg()), 16'b10000);
      idle_inputs();
      cyc(DOOR_HOLD + 2);

      // Camera sweep with a wrong code.
      bus.access_code = 12'd191;
      for (int i = 0; i < 4; i++) begin
         v = {1'b1, 2'(i)};
         set_cam(i, v);
         cyc(1);
         check("sweep_sec", 16'(dut_sec()), 16'(4'b0001 << i));
         set_cam(i, 3'b000);
      end
      check("sweep_door", 16'(bus.door), 16'h0);

      // Cross-routing and OR of several hits.
      idle_inputs();
      bus.mds2 = 3'b100; bus.cam3 = 3'b100;
      cyc(1);
      check("cross_same_sector", 16'(dut_sec()), 16'b0001);
      bus.mds2 = 3'b000; bus.cam3 = 3'b000;
      bus.mds1 = 3'b111; bus.cam0 = 3'b101;
      cyc(1);
      check("cross_two_sectors", 16'(dut_sec()), 16'b1010);
      idle_inputs();
      cyc(2);

      // Door hold: one-cycle match, then 1 + DOOR_HOLD cycles open.
      bus.access_code = 12'd123;
      door_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (bus.door) door_cnt++;
         if (i == 0) bus.access_code = 12'd0;
      end
      check("door_hold_cycles", 16'(door_cnt), 16'd9);
      bus.access_code = 12'd200;
      cyc(3);
      check("door_bad_code", 16'(bus.door), 16'h0);

      // Fire with a wrong code, then the hold.
      bus.access_code = 12'd294;
      bus.fire = 1'b1;
      cyc(3);
      check("fire_outputs", 16'(dut_emg()), 16'b11111);
      bus.fire = 1'b0;
      alarm_cnt = 0;
      alert_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (bus.fire_alarm) alarm_cnt++;
         if (bus.fire_dept_alert) alert_cnt++;
      end
      check("fire_alarm_hold", 16'(alarm_cnt), 16'd16);
      check("fire_alert_hold", 16'(alert_cnt), 16'd16);
      check("fire_hold_expired", 16'(dut_emg()), 16'h0);

      // Earthquake, then both, then reset mid-hold.
      bus.earth_quake = 1'b1;
      cyc(2);
      check("quake_outputs", 16'(dut_emg()), 16'b11011);
      bus.fire = 1'b1;
      cyc(1);
      check("quake_fire_alert", 16'(dut_emg()), 16'b11111);
      bus.fire = 1'b0;
      bus.earth_quake = 1'b0;
      bus.mds3 = 3'b110;
      cyc(5);
      #2 rst_n = 1'b0;
      #1 check("reset_mid_hold", 16'(dut_out()), 16'h0);
      cyc(2);
      idle_inputs();
      rst_n = 1'b1;
      cyc(2);
      check("post_reset_clear", 16'(dut_out()), 16'h0);

      // Mixed traffic for the per-cycle comparison.
      bus.access_code = 12'd123; bus.mds0 = 3'b110; bus.cam2 = 3'b101;
      cyc(1);
      bus.access_code = 12'd0; bus.earth_quake = 1'b1; bus.mds0 = 3'b000;
      cyc(2);
      bus.earth_quake = 1'b0; bus.fire = 1'b1; bus.cam2 = 3'b011;
      cyc(1);
      idle_inputs();
      cyc(25);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
